// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV64I decode-stage immediate generator with a registered
// valid/ready output stage and a one-entry skid register behind it.
//
// Parameters:
//   WIDTH  - width of out_imm (32 or 64)
//   TAG_W  - width of the sideband tag carried with each instruction
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_valid/in_ready       - input handshake
//   in_instr, in_tag        - raw instruction word and its tag (PC)
//   out_valid/out_ready     - output handshake
//   out_imm                 - sign-extended immediate
//   out_fmt                 - 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_illegal             - opcode not recognised
//   out_instr, out_tag      - instruction and tag passed through
module imm_gen_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("imm_gen_pipe: WIDTH must be 32 or 64");
    end

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // ---------------- combinational decode ----------------
    logic [31:0]      dec_imm32;
    logic [WIDTH-1:0] dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_fmt   = FMT_I;
                dec_ill   = 1'b0;
            end
            7'b0100011: begin
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_fmt   = FMT_S;
                dec_ill   = 1'b0;
            end
            7'b1100011: begin
                dec_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
                dec_fmt   = FMT_B;
                dec_ill   = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {in_instr[31:12], 12'b0};
                dec_fmt   = FMT_U;
                dec_ill   = 1'b0;
            end
            7'b1101111: begin
                dec_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
                dec_fmt   = FMT_J;
                dec_ill   = 1'b0;
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FMT_R;
                dec_ill = 1'b0;
            end
            default: ;
        endcase
    end

    // dec_imm32 is already sign-correct (zero for R/illegal), so widening
    // replicates its own bit 31 rather than in_instr[31].
    if (WIDTH > 32) begin : g_ext
        assign dec_imm = {{(WIDTH-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_noext
        assign dec_imm = dec_imm32;
    end

    // ---------------- main (M) and skid (S) registers ----------------
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    logic [2:0]       m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
    logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
    logic [31:0]      m_instr_q, m_instr_d, s_instr_q, s_instr_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;

    logic in_fire, out_fire;

    assign in_ready = !s_valid_q && !reset;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = m_valid_q && out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_imm_d   = m_imm_q;
        m_fmt_d   = m_fmt_q;
        m_ill_d   = m_ill_q;
        m_instr_d = m_instr_q;
        m_tag_d   = m_tag_q;
        s_valid_d = s_valid_q;
        s_imm_d   = s_imm_q;
        s_fmt_d   = s_fmt_q;
        s_ill_d   = s_ill_q;
        s_instr_d = s_instr_q;
        s_tag_d   = s_tag_q;

        // in_fire cannot coincide with a valid skid entry (in_ready is low).
        if (out_fire && s_valid_q) begin
            m_valid_d = 1'b1;
            m_imm_d   = s_imm_q;
            m_fmt_d   = s_fmt_q;
            m_ill_d   = s_ill_q;
            m_instr_d = s_instr_q;
            m_tag_d   = s_tag_q;
            s_valid_d = 1'b0;
        end else if (in_fire && (!m_valid_q || out_fire)) begin
            m_valid_d = 1'b1;
            m_imm_d   = dec_imm;
            m_fmt_d   = dec_fmt;
            m_ill_d   = dec_ill;
            m_instr_d = in_instr;
            m_tag_d   = in_tag;
        end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_imm_d   = dec_imm;
            s_fmt_d   = dec_fmt;
            s_ill_d   = dec_ill;
            s_instr_d = in_instr;
            s_tag_d   = in_tag;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_imm_q   <= '0;
            m_fmt_q   <= '0;
            m_ill_q   <= 1'b0;
            m_instr_q <= '0;
            m_tag_q   <= '0;
            s_valid_q <= 1'b0;
            s_imm_q   <= '0;
            s_fmt_q   <= '0;
            s_ill_q   <= 1'b0;
            s_instr_q <= '0;
            s_tag_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_imm_q   <= m_imm_d;
            m_fmt_q   <= m_fmt_d;
            m_ill_q   <= m_ill_d;
            m_instr_q <= m_instr_d;
            m_tag_q   <= m_tag_d;
            s_valid_q <= s_valid_d;
            s_imm_q   <= s_imm_d;
            s_fmt_q   <= s_fmt_d;
            s_ill_q   <= s_ill_d;
            s_instr_q <= s_instr_d;
            s_tag_q   <= s_tag_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_imm     = m_imm_q;
    assign out_fmt     = m_fmt_q;
    assign out_illegal = m_ill_q;
    assign out_instr   = m_instr_q;
    assign out_tag     = m_tag_q;

endmodule
